decoder: RTL and testbench

Instruction decoder for the APCPU datapath. It sits between the instruction fetch stage and the ALU/register file. Each cycle it registers one 32-bit instruction word and splits it into an ALU opcode, three register-file selects and a 24-bit operand, shaped by a 3-bit operand-mode select. An 8-bit debug status byte is also produced for bring-up.

---
 rtl/decoder.sv | 111 +++++++++++
 tb/tb_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// APCPU instruction decoder.
// Registers one 32-bit instruction word per cycle and splits it into an ALU
// opcode, three register-file selects and a 24-bit operand shaped by the
// operand-mode select. All outputs are registered with one clock of latency.
// Optional feature macro: DECODER_DEBUG_EN builds the debug status byte
// (cycle counter, instruction parity, sampled mode). Without it debbug is 0.
module decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] InstructionBus,
    input  logic [2:0]  APSelBus,
    output logic [7:0]  AluCode,
    output logic [23:0] DecoderData,
    output logic [2:0]  RegSelX,
    output logic [2:0]  RegSelY,
    output logic [2:0]  RegSelZ,
    output logic [7:0]  debbug
);

    // Odd parity of the full instruction word.
    function automatic logic parity32(input logic [31:0] word);
        parity32 = ^word;
    endfunction

    // Operand formatting for each operand mode.
    function automatic logic [23:0] shape_operand(input logic [31:0] instr,
                                                  input logic [2:0]  mode);
        logic [23:0] res;
        case (mode)
            3'd0:    res = instr[23:0];
            3'd1:    res = {9'b0_0000_0000, instr[14:0]};
            3'd2:    res = {{9{instr[14]}}, instr[14:0]};
            3'd3:    res = {instr[14:0], 9'b0_0000_0000};
            3'd4:    res = {16'h0000, instr[7:0]};
            3'd5:    res = {{16{instr[7]}}, instr[7:0]};
            3'd6:    res = {8'h00, instr[15:0]};
            3'd7:    res = 24'h00_0000;
            default: res = 24'h00_0000;
        endcase
        shape_operand = res;
    endfunction

    logic [7:0]  alu_code_d,  alu_code_q;
    logic [23:0] data_d,      data_q;
    logic [2:0]  sel_x_d,     sel_x_q;
    logic [2:0]  sel_y_d,     sel_y_q;
    logic [2:0]  sel_z_d,     sel_z_q;

    // Next-state decode of the current instruction word and mode.
    always_comb begin
        alu_code_d = InstructionBus[31:24];
        sel_x_d    = InstructionBus[23:21];
        sel_y_d    = InstructionBus[20:18];
        sel_z_d    = InstructionBus[17:15];
        data_d     = shape_operand(InstructionBus, APSelBus);
    end

    // Decode pipeline register; reset discards any in-flight decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_code_q <= 8'h00;
            data_q     <= 24'h00_0000;
            sel_x_q    <= 3'd0;
            sel_y_q    <= 3'd0;
            sel_z_q    <= 3'd0;
        end else begin
            alu_code_q <= alu_code_d;
            data_q     <= data_d;
            sel_x_q    <= sel_x_d;
            sel_y_q    <= sel_y_d;
            sel_z_q    <= sel_z_d;
        end
    end

`ifdef DECODER_DEBUG_EN
    logic [3:0] cnt_d,    cnt_q;
    logic       parity_d, parity_q;
    logic [2:0] mode_d,   mode_q;

    // Next-state for the debug byte: counter wraps naturally at 4 bits.
    always_comb begin
        cnt_d    = cnt_q + 4'd1;
        parity_d = parity32(InstructionBus);
        mode_d   = APSelBus;
    end

    // Debug status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            parity_q <= 1'b0;
            mode_q   <= 3'd0;
        end else begin
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            mode_q   <= mode_d;
        end
    end

    assign debbug = {cnt_q, parity_q, mode_q};
`else
    assign debbug = 8'h00;
`endif

    assign AluCode     = alu_code_q;
    assign DecoderData = data_q;
    assign RegSelX     = sel_x_q;
    assign RegSelY     = sel_y_q;
    assign RegSelZ     = sel_z_q;

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for the APCPU instruction decoder.
module tb_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] InstructionBus;
    logic [2:0]  APSelBus;
    logic [7:0]  AluCode;
    logic [23:0] DecoderData;
    logic [2:0]  RegSelX;
    logic [2:0]  RegSelY;
    logic [2:0]  RegSelZ;
    logic [7:0]  debbug;

    int         checks;
    int         failures;
    logic [3:0] exp_cnt;

    decoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .InstructionBus (InstructionBus),
        .APSelBus       (APSelBus),
        .AluCode        (AluCode),
        .DecoderData    (DecoderData),
        .RegSelX        (RegSelX),
        .RegSelY        (RegSelY),
        .RegSelZ        (RegSelZ),
        .debbug         (debbug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected debug byte for the active build.
    function automatic logic [7:0] exp_dbg(input logic [3:0] c,
                                           input logic [31:0] i,
                                           input logic [2:0] s);
`ifdef DECODER_DEBUG_EN
        exp_dbg = {c, ^i, s};
`else
        exp_dbg = 8'h00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a word between edges, clock it in, sample 1 time unit after the edge.
    task automatic step(input logic [31:0] instr, input logic [2:0] sel);
        @(negedge clk);
        InstructionBus = instr;
        APSelBus       = sel;
        @(posedge clk);
        exp_cnt = exp_cnt + 4'd1;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_alu"},  {24'h0, AluCode},     32'h0);
        chk({tag, "_data"}, {8'h0, DecoderData},  32'h0);
        chk({tag, "_sel"},  {23'h0, RegSelX, RegSelY, RegSelZ}, 32'h0);
        chk({tag, "_dbg"},  {24'h0, debbug},      32'h0);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] instr, input logic [2:0] sel,
                            input logic [7:0] e_alu, input logic [2:0] e_x, input logic [2:0] e_y,
                            input logic [2:0] e_z, input logic [23:0] e_data);
        chk({tag, "_alu"},  {24'h0, AluCode},    {24'h0, e_alu});
        chk({tag, "_x"},    {29'h0, RegSelX},    {29'h0, e_x});
        chk({tag, "_y"},    {29'h0, RegSelY},    {29'h0, e_y});
        chk({tag, "_z"},    {29'h0, RegSelZ},    {29'h0, e_z});
        chk({tag, "_data"}, {8'h0, DecoderData}, {8'h0, e_data});
        chk({tag, "_dbg"},  {24'h0, debbug},     {24'h0, exp_dbg(exp_cnt, instr, sel)});
    endtask

    initial begin
        logic [23:0] sweep_a [8];
        logic [23:0] sweep_b [8];
        checks   = 0;
        failures = 0;
        exp_cnt  = 4'd0;

        sweep_a[0] = 24'h64AD48; sweep_a[1] = 24'h002D48; sweep_a[2] = 24'h002D48;
        sweep_a[3] = 24'h5A9000; sweep_a[4] = 24'h000048; sweep_a[5] = 24'h000048;
        sweep_a[6] = 24'h00AD48; sweep_a[7] = 24'h000000;
        sweep_b[0] = 24'h00C0F0; sweep_b[1] = 24'h0040F0; sweep_b[2] = 24'hFFC0F0;
        sweep_b[3] = 24'h81E000; sweep_b[4] = 24'h0000F0; sweep_b[5] = 24'hFFFFF0;
        sweep_b[6] = 24'h00C0F0; sweep_b[7] = 24'h000000;

        // Reset held with clock running and all-ones instruction.
        rst_n          = 1'b0;
        InstructionBus = 32'hFFFF_FFFF;
        APSelBus       = 3'd7;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_hold");

        @(negedge clk);
        rst_n = 1'b1;

        // Base decode, first capture after release: counter becomes 1.
        step(32'hC464AD48, 3'd0);
        chk("first_cnt_dbg", {24'h0, debbug}, {24'h0, exp_dbg(4'd1, 32'hC464AD48, 3'd0)});
        chk_word("base", 32'hC464AD48, 3'd0, 8'hC4, 3'd3, 3'd1, 3'd1, 24'h64AD48);

        // Mode sweep on word A.
        for (int m = 1; m < 8; m++) begin
            step(32'hC464AD48, m[2:0]);
            chk_word($sformatf("sweepA_m%0d", m), 32'hC464AD48, m[2:0],
                     8'hC4, 3'd3, 3'd1, 3'd1, sweep_a[m]);
        end

        // Sign-extension word B over all modes.
        for (int m = 0; m < 8; m++) begin
            step(32'h0100C0F0, m[2:0]);
            chk_word($sformatf("sweepB_m%0d", m), 32'h0100C0F0, m[2:0],
                     8'h01, 3'd0, 3'd0, 3'd1, sweep_b[m]);
        end

        // Back-to-back alternation with mode changing alongside the word.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                step(32'hC464AD48, 3'd3);
                chk_word($sformatf("b2b_%0d", k), 32'hC464AD48, 3'd3,
                         8'hC4, 3'd3, 3'd1, 3'd1, 24'h5A9000);
            end else begin
                step(32'h0100C0F0, 3'd5);
                chk_word($sformatf("b2b_%0d", k), 32'h0100C0F0, 3'd5,
                         8'h01, 3'd0, 3'd0, 3'd1, 24'hFFFFF0);
            end
        end

        // Asynchronous reset mid-run: outputs clear with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        #1;
        chk_all_zero("reset_edge");
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 4'd0;

        // Counter sequence over 17 clocks after release: 1..15, 0, 1.
        for (int n = 1; n <= 17; n++) begin
            logic [3:0] want;
            want = n[3:0];
            step(32'h0000_0001, 3'd6);
            chk($sformatf("cnt_%0d", n), {24'h0, debbug},
                {24'h0, exp_dbg(want, 32'h0000_0001, 3'd6)});
            chk($sformatf("cnt_data_%0d", n), {8'h0, DecoderData}, 32'h0000_0001);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety timeout so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
